// File: rtl/bdiv12by6.sv
// Sequential restoring divider: NW-bit dividend by DW-bit divisor, one quotient bit per clock.
// Valid/ready on both sides; the result is held in DONE until it is consumed.
//
//   state  | meaning
//   -------+---------------------------------------------------
//   S_IDLE | waiting for operands, in_ready=1
//   S_CALC | NW shift/compare/subtract iterations, MSB first
//   S_DONE | result presented with out_valid=1 until out_ready
module bdiv12by6 #(
    parameter int DW = 6,
    parameter int NW = 2 * DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          dbz
);

    localparam int CW = $clog2(NW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   div_q, div_d;
    logic [DW-1:0]   nlo_q, nlo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zdiv_q, zdiv_d;
    logic [NW-1:0]   q_q, q_d;
    logic [DW-1:0]   r_q, r_d;
    logic            dbz_q, dbz_d;

    logic [DW:0]     rem_sh;
    logic            ge;
    logic [DW-1:0]   rem_nx;
    logic [NW-1:0]   quo_nx;

    // One restoring step; the remainder stays below the divisor, so it fits in DW bits.
    always_comb begin
        rem_sh = {rem_q, quo_q[NW-1]};
        ge     = (rem_sh >= {1'b0, div_q});
        rem_nx = ge ? DW'(rem_sh - {1'b0, div_q}) : rem_sh[DW-1:0];
        quo_nx = {quo_q[NW-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        nlo_d   = nlo_q;
        cnt_d   = cnt_q;
        zdiv_d  = zdiv_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    quo_d   = N;
                    nlo_d   = N[DW-1:0];
                    div_d   = D;
                    rem_d   = '0;
                    cnt_d   = CW'(NW - 1);
                    zdiv_d  = (D == '0);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q == '0) begin
                    // Divide-by-zero still runs full length; only the presented result is forced.
                    q_d     = zdiv_q ? '1 : quo_nx;
                    r_d     = zdiv_q ? nlo_q : rem_nx;
                    dbz_d   = zdiv_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            nlo_q   <= '0;
            cnt_q   <= '0;
            zdiv_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            nlo_q   <= nlo_d;
            cnt_q   <= cnt_d;
            zdiv_q  <= zdiv_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Q         = q_q;
    assign R         = r_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_bdiv12by6.sv
// Self-checking bench for bdiv12by6: directed cases, backpressure, mid-operation reset and
// randomized operands compared against plain integer division.
module tb_bdiv12by6;

    localparam int DW = 6;
    localparam int NW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [NW-1:0] n_in = '0;
    logic [DW-1:0] d_in = '0;
    logic          in_ready, out_valid, dbz;
    logic [NW-1:0] q;
    logic [DW-1:0] r;

    int n_vec = 0;
    int n_err = 0;

    bdiv12by6 #(.DW(DW), .NW(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .N        (n_in),
        .D        (d_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Q        (q),
        .R        (r),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic ref_div(input int nn, input int dd, output int qq, output int rr, output int dz);
        if (dd == 0) begin
            qq = (1 << NW) - 1;
            rr = nn % (1 << DW);
            dz = 1;
        end else begin
            qq = nn / dd;
            rr = nn % dd;
            dz = 0;
        end
    endtask

    // Called at a negedge. Applies one operation, checks latency/result, optional backpressure hold,
    // then consumes the result and returns at a negedge.
    task automatic run_op(input int nn, input int dd, input string tag, input bit chk_lat, input int hold);
        int qe, re, de, lat, wt;
        logic [NW-1:0] q0;
        logic [DW-1:0] r0;
        logic          z0;
        wt = 0;
        while (!in_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        n_in     = NW'(nn);
        d_in     = DW'(dd);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_in     = NW'($urandom);
        d_in     = DW'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        if (chk_lat) chk({tag, "_latency"}, lat, NW);
        chk({tag, "_out_valid"}, out_valid, 1);
        ref_div(nn, dd, qe, re, de);
        chk({tag, "_Q"}, q, qe);
        chk({tag, "_R"}, r, re);
        chk({tag, "_dbz"}, dbz, de);
        q0 = q;
        r0 = r;
        z0 = dbz;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            n_in     = NW'($urandom);
            d_in     = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_bp_valid"}, out_valid, 1);
            chk({tag, "_bp_ready"}, in_ready, 0);
            chk({tag, "_bp_stable"}, {q, r, dbz}, {q0, r0, z0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_consumed"}, out_valid, 0);
        chk({tag, "_next_ready"}, in_ready, 1);
        chk({tag, "_hold_after"}, {q, r, dbz}, {q0, r0, z0});
    endtask

    initial begin
        int a, b;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Q", q, 0);
        chk("rst_R", r, 0);
        chk("rst_dbz", dbz, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // out_ready with nothing valid must not disturb the idle block
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_oready", {out_valid, in_ready}, 2'b01);

        run_op(3969, 63, "sq63", 1'b1, 0);
        run_op(100, 7, "d100_7", 1'b1, 0);
        run_op(4095, 1, "d4095_1", 1'b0, 0);
        run_op(5, 63, "d5_63", 1'b0, 0);
        run_op(12'hABC, 0, "dbz", 1'b1, 0);
        run_op(10, 3, "d10_3", 1'b1, 0);
        run_op(2500, 50, "bp", 1'b1, 20);
        run_op(10, 3, "pre_rst", 1'b0, 0);

        // Reset during the 5th iteration
        in_valid = 1'b1;
        n_in     = 12'd4000;
        d_in     = 6'd37;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_Q", q, 0);
        chk("mid_rst_R", r, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {out_valid, in_ready}, 2'b01);
        run_op(63 * 45, 45, "post_rst", 1'b1, 0);

        for (int i = 0; i < 1500; i++) begin
            a = $urandom_range(0, 63);
            b = $urandom_range(1, 63);
            run_op(a * b, b, "round_trip", 1'b0, 0);
            chk("rt_Q_eq_A", q, a);
            chk("rt_R_zero", r, 0);
        end
        for (int i = 0; i < 1500; i++) begin
            a = $urandom_range(0, 4095);
            b = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 63);
            run_op(a, b, "rand", 1'b0, (i % 100 == 0) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
